reg_mask_enc: RTL
=================

# reg_mask_enc

Sequential register-list encoder: the index-producing counterpart of the write-select decoder tree. It accepts a 32-bit multi-hot register mask and emits the 5-bit index of each set bit, one per accepted handshake, lowest index first. It is used by the decode/execute stages to walk a register list for multi-register transfers, such as block load/store, and to drive the register-file port address one register at a time.

## Interface
Parameters:
- WIDTH, 32, mask width (number of architectural registers); a power of 2.
- IDXW, 5, index width; equals log2(WIDTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to begin encoding `mask`; sampled only in IDLE.
- mask  input  WIDTH  register list; sampled on the accepted `start` cycle only.
- out_ready  input  1  consumer can take the current index this cycle.
- out_valid  output  1  `out_idx` holds a valid register index.
- out_idx  output  IDXW  index of the lowest set bit still pending; 0 when `out_valid` = 0.
- out_last  output  1  qualifies `out_valid`: the current index is the final one of the list.
- busy  output  1  state ≠ IDLE.
- done  output  1  one-cycle pulse: the list has been fully emitted.
- count  output  IDXW+1  number of indices handed off since the last accepted `start`.

## Operation
- State register: IDLE, RUN, DONE. A `pending` register is WIDTH bits wide. A `count` register is IDXW+1 bits wide.
- IDLE:
  - On `start` = 1, latch `pending` ← `mask` and clear `count` to 0.
  - Go to RUN if `mask` ≠ 0; otherwise go to DONE.
- RUN:
  - `out_valid` = 1.
  - `out_idx` = priority encode of `pending`: the lowest set bit wins.
  - `out_last` = 1 iff exactly one bit of `pending` is set.
- Handshake: occurs when `out_valid` & `out_ready`.
  - On a handshake, clear bit `out_idx` of `pending` and increment `count`.
  - If `out_last` was 1, go to DONE.
- DONE: `done` = 1 for exactly one cycle, then go to IDLE.
- `start` is ignored in RUN and DONE; it does not queue.
- `mask` changes outside the accepting cycle have no effect.
- `count` holds its final value after DONE until the next accepted `start`. Its maximum value is 32, which requires the IDXW+1 width.
- `out_idx`, `out_valid` and `out_last` are functions of registered state only. They are stable while the consumer stalls.
- Reset: state = IDLE, `pending` = 0, `count` = 0. This gives `out_valid` = 0, `out_idx` = 0, `out_last` = 0, `busy` = 0, `done` = 0.

## Timing
- Accepted `start` in cycle N: `busy` = 1 and `out_valid` = 1 from cycle N+1.
- List with k set bits, `out_ready` held high:
  - Indices are presented in cycles N+1 through N+k.
  - `done` = 1 in cycle N+k+1.
  - IDLE is reached in N+k+2, where a new `start` is accepted.
- Each cycle with `out_ready` = 0 during RUN adds one cycle of latency. `out_idx` is held unchanged during the stall.
- Zero mask: `start` accepted in cycle N, `done` = 1 in N+1, `count` = 0, `out_valid` never asserts.
- Throughput: one index per cycle. No bubble between consecutive indices of one list.
- `reset` asserted in any state, including mid-RUN:
  - At the next edge, all state returns to reset values and the in-flight list is discarded.
  - No `done` pulse is produced for the discarded list.
- `reset` has priority over `start` in the same cycle.

## Test plan
- Single register: `start` with mask 0x0000_0001, `out_ready` = 1.
  - Required: idx 0 with `out_last` = 1 in cycle N+1, then `done` in N+2, `count` = 1.
- Sparse list: mask 0x8000_0005.
  - Required: idx 0, 2, 31 in consecutive cycles; `out_last` only on 31; `count` = 3; `done` one cycle after idx 31.
- Backpressure: mask 0x0000_0030 with `out_ready` low for 3 cycles at the first index.
  - Required: idx 4 held stable for 4 cycles, then idx 5, then `done`.
  - Required: no index is skipped or duplicated.
- Full and zero lists:
  - mask 0xFFFF_FFFF: required idx 0..31 over 32 cycles, `count` = 32, then `done`.
  - mask 0: required `done` one cycle after `start`, `out_valid` never 1.
- Ignored start: pulse `start` with mask 0x0000_0100 while RUN on mask 0x0000_0003.
  - Required: only idx 0 and 1 are emitted; `pending` is unaffected by the second `start`.
- Reset mid-run: assert `reset` after the second index of mask 0x0000_00FF.
  - Required: at the next edge all outputs are 0, with no `done` pulse.
  - Required: a subsequent `start` with 0x0000_0002 yields idx 1 normally.

Source files
------------

// File: rtl/reg_mask_enc_if.sv
// Handshake and status bundle for the register-list encoder.
// master: the block that requests a list and consumes indices.
// slave:  the encoder itself.
interface reg_mask_enc_if #(
  parameter int WIDTH = 32,
  parameter int IDXW  = 5
);

  logic              start;
  logic [WIDTH-1:0]  mask;
  logic              out_ready;
  logic              out_valid;
  logic [IDXW-1:0]   out_idx;
  logic              out_last;
  logic              busy;
  logic              done;
  logic [IDXW:0]     count;

  modport master (
    output start, mask, out_ready,
    input  out_valid, out_idx, out_last, busy, done, count
  );

  modport slave (
    input  start, mask, out_ready,
    output out_valid, out_idx, out_last, busy, done, count
  );

endinterface

// File: rtl/reg_mask_enc.sv
// Sequential register-list encoder: walks a multi-hot register mask and
// hands out one set-bit index per accepted handshake, lowest index first.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; mask is latched on the accepting cycle
//   RUN   | presenting the lowest pending index until it is taken
//   DONE  | one-cycle completion pulse, then back to IDLE
module reg_mask_enc #(
  parameter int WIDTH = 32,
  parameter int IDXW  = 5
) (
  input  logic            clk,
  input  logic            reset,
  reg_mask_enc_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [WIDTH-1:0]  pending_q;
  logic [IDXW:0]     count_q;

  logic [IDXW-1:0]   enc_idx;
  logic              one_left;
  logic [WIDTH-1:0]  pending_drop_low;
  logic              run;
  logic              handshake;
  logic              accept;

  // Lowest-set-bit priority encoder; scanning downward lets the lowest bit win.
  always_comb begin
    enc_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        enc_idx = i[IDXW-1:0];
      end
    end
  end

  // Clearing the lowest set bit is the same as clearing bit enc_idx, and
  // x & (x-1) also tells us whether exactly one bit remains.
  assign pending_drop_low = pending_q & (pending_q - WIDTH'(1));
  assign one_left         = (pending_q != '0) && (pending_drop_low == '0);

  assign run       = (state_q == RUN);
  assign handshake = run && bus.out_ready;
  assign accept    = (state_q == IDLE) && bus.start;

  // Next-state decode; start is only honoured from IDLE so it never queues.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = (bus.mask != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (bus.out_ready && one_left) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset; reset discards any in-flight list.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pending list and handoff counter; count holds after DONE until next start.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      count_q   <= '0;
    end else if (accept) begin
      pending_q <= bus.mask;
      count_q   <= '0;
    end else if (handshake) begin
      pending_q <= pending_drop_low;
      count_q   <= count_q + {{IDXW{1'b0}}, 1'b1};
    end
  end

  // Outputs come from registered state only, so they hold steady under stall.
  assign bus.out_valid = run;
  assign bus.out_idx   = run ? enc_idx : '0;
  assign bus.out_last  = run && one_left;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.count     = count_q;

endmodule
